// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared enums and width helpers for the ECC stream engine
package ecc_pkg;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_FULL = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        WIDTH_8  = 2'b00,
        WIDTH_16 = 2'b01,
        WIDTH_32 = 2'b10
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_DEC,
        ST_OUT
    } state_e;

    function automatic int PARITY_W(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int n_of(input width_e w);
        case (w)
            WIDTH_8:  return 8;
            WIDTH_16: return 16;
            default:  return 32;
        endcase
    endfunction

    function automatic int k_of(input width_e w);
        case (w)
            WIDTH_8:  return 4;
            WIDTH_16: return 11;
            default:  return 26;
        endcase
    endfunction

    // Hamming position of info bit i: the i-th position that is not a power of two
    function automatic int data_pos(input int i);
        int d;
        int res;
        d   = 0;
        res = 0;
        for (int p = 3; p < 64; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d == i) res = p;
                d++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_stream_engine_if.sv
// rtl/ecc_stream_engine_if.sv - input/output word streams of the ECC stream engine
interface ecc_stream_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] in_noise;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_num_errors;

    modport master (
        output in_valid, in_data, in_noise, out_ready,
        input  in_ready, out_valid, out_data, out_num_errors
    );

    modport slave (
        input  in_valid, in_data, in_noise, out_ready,
        output in_ready, out_valid, out_data, out_num_errors
    );
endinterface

// File: rtl/ecc_secded_codec.sv
// rtl/ecc_secded_codec.sv - combinational extended-Hamming SECDED encode and decode
module ecc_secded_codec
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  width_e                width,
    input  logic [DATA_WIDTH-1:0] enc_info,
    output logic [DATA_WIDTH-1:0] enc_cw,
    input  logic [DATA_WIDTH-1:0] dec_cw,
    output logic [DATA_WIDTH-1:0] dec_info,
    output logic [1:0]            dec_num_errors
);
    localparam int R = PARITY_W(DATA_WIDTH) - 1;
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    function automatic logic [R-1:0] hamming_par(input logic [DATA_WIDTH-1:0] info);
        logic [R-1:0] par;
        int pos;
        par = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = data_pos(i);
            for (int j = 0; j < R; j++) begin
                if (pos[j]) par[j] = par[j] ^ info[i];
            end
        end
        return par;
    endfunction

    // Layout: info in [k-1:0], Hamming parity in [n-2:k], overall parity at n-1
    logic [DATA_WIDTH-1:0] info_mask, par_mask, cw_mask, enc_body, rx_info;
    logic [R-1:0]          syndrome;
    logic                  overall;

    always_comb begin
        info_mask = ~(ONES << k_of(width));
        cw_mask   = ~(ONES << n_of(width));
        par_mask  = ~(ONES << (n_of(width) - 1)) & ~info_mask;
        enc_body  = (enc_info & info_mask)
                  | ((DATA_WIDTH'(hamming_par(enc_info & info_mask)) << k_of(width)) & par_mask);
        enc_cw    = enc_body | (DATA_WIDTH'(^enc_body) << (n_of(width) - 1));
    end

    always_comb begin
        rx_info        = dec_cw & info_mask;
        syndrome       = hamming_par(rx_info) ^ R'((dec_cw & par_mask) >> k_of(width));
        overall        = ^(dec_cw & cw_mask);
        dec_info       = rx_info;
        dec_num_errors = 2'd0;
        if (overall) begin
            dec_num_errors = 2'd1;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (data_pos(i) == int'(syndrome)) dec_info[i] = ~rx_info[i];
            end
        end else if (syndrome != '0) begin
            dec_num_errors = 2'd2;
        end
    end

endmodule

// File: rtl/ecc_stream_engine.sv
// rtl/ecc_stream_engine.sv - FIFO-buffered SECDED encode/noise/decode pipeline with statistics
module ecc_stream_engine
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_mode,
    input  logic [1:0]            cfg_width,
    output logic                  cfg_err,
    ecc_stream_engine_if.slave    stream,
    output logic                  operation_done,
    output logic                  busy,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  stat_words,
    output logic [CNT_WIDTH-1:0]  stat_corr,
    output logic [CNT_WIDTH-1:0]  stat_uncorr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_e                state, work_state;
    mode_e                 mode;
    width_e                width;
    logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_noise [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, push, pop, handshake;
    logic [DATA_WIDTH-1:0] stage_data, stage_noise, stage_cw, res_data;
    logic [DATA_WIDTH-1:0] enc_cw, dec_info;
    logic [1:0]            res_num, dec_num;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign handshake  = (state == ST_OUT) && stream.out_ready;
    assign push       = stream.in_valid && !fifo_full;
    assign pop        = !fifo_empty && ((state == ST_IDLE) || handshake);
    assign work_state = (mode == MODE_DEC) ? ST_DEC : ST_ENC;

    assign stream.in_ready       = !fifo_full;
    assign stream.out_valid      = state == ST_OUT;
    assign stream.out_data       = res_data;
    assign stream.out_num_errors = res_num;
    assign operation_done        = handshake && fifo_empty;
    assign busy                  = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr[AW-1:0]]  <= stream.in_data;
                fifo_noise[wr_ptr[AW-1:0]] <= stream.in_noise;
                wr_ptr                     <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Reserved encodings fold onto enc-only and the 32-bit width
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode    <= MODE_ENC;
            width   <= WIDTH_32;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && busy;
            if (cfg_we && !busy) begin
                mode  <= (cfg_mode == 2'b11) ? MODE_ENC : mode_e'(cfg_mode);
                width <= (cfg_width == 2'b11) ? WIDTH_32 : width_e'(cfg_width);
            end
        end
    end

    ecc_secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_codec (
        .width          (width),
        .enc_info       (stage_data),
        .enc_cw         (enc_cw),
        .dec_cw         (stage_cw),
        .dec_info       (dec_info),
        .dec_num_errors (dec_num)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            stage_data  <= '0;
            stage_noise <= '0;
            stage_cw    <= '0;
            res_data    <= '0;
            res_num     <= 2'd0;
        end else begin
            // stage_cw is loaded with the raw word so dec-only mode can skip ENC
            if (pop) begin
                stage_data  <= fifo_data[rd_ptr[AW-1:0]];
                stage_noise <= fifo_noise[rd_ptr[AW-1:0]];
                stage_cw    <= fifo_data[rd_ptr[AW-1:0]];
            end
            case (state)
                ST_IDLE: if (pop) state <= work_state;
                ST_ENC: begin
                    if (mode == MODE_ENC) begin
                        res_data <= enc_cw;
                        res_num  <= 2'd0;
                        state    <= ST_OUT;
                    end else begin
                        stage_cw <= enc_cw ^ stage_noise;
                        state    <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    res_data <= dec_info;
                    res_num  <= dec_num;
                    state    <= ST_OUT;
                end
                ST_OUT: if (handshake) state <= pop ? work_state : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || stat_clr) begin
            stat_words  <= '0;
            stat_corr   <= '0;
            stat_uncorr <= '0;
        end else if (handshake) begin
            stat_words <= sat_inc(stat_words);
            if (res_num == 2'd1) stat_corr <= sat_inc(stat_corr);
            if (res_num == 2'd2) stat_uncorr <= sat_inc(stat_uncorr);
        end
    end

endmodule

// File: tb/tb_ecc_stream_engine.sv
// tb/tb_ecc_stream_engine.sv - directed self-checking bench for ecc_stream_engine
module tb_ecc_stream_engine;

    logic        clk = 1'b0;
    logic        rst, cfg_we, cfg_err, operation_done, busy, stat_clr;
    logic [1:0]  cfg_mode, cfg_width;
    logic [15:0] stat_words, stat_corr, stat_uncorr;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ecc_stream_engine_if #(.DATA_WIDTH(32)) sif ();

    ecc_stream_engine #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_mode       (cfg_mode),
        .cfg_width      (cfg_width),
        .cfg_err        (cfg_err),
        .stream         (sif),
        .operation_done (operation_done),
        .busy           (busy),
        .stat_clr       (stat_clr),
        .stat_words     (stat_words),
        .stat_corr      (stat_corr),
        .stat_uncorr    (stat_uncorr)
    );

    task automatic do_reset();
        rst = 1'b0; cfg_we = 1'b0; cfg_mode = 2'b00; cfg_width = 2'b00; stat_clr = 1'b0;
        sif.in_valid = 1'b0; sif.in_data = '0; sif.in_noise = '0; sif.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic configure(input logic [1:0] m, input logic [1:0] w);
        cfg_we = 1'b1; cfg_mode = m; cfg_width = w;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_and_wait(input logic [31:0] data, input logic [31:0] noise, output int lat);
        sif.in_valid = 1'b1; sif.in_data = data; sif.in_noise = noise;
        @(negedge clk);
        sif.in_valid = 1'b0;
        lat = 1;
        while (sif.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept(output logic done);
        sif.out_ready = 1'b1;
        #1;
        done = operation_done;
        @(negedge clk);
        sif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", sif.out_valid); end
        checks++; if (sif.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", sif.in_ready); end
        checks++; if (busy !== 1'b0 || cfg_err !== 1'b0 || operation_done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b%0b exp=000", busy, cfg_err, operation_done); end
        checks++; if (sif.out_data !== 32'h0 || sif.out_num_errors !== 2'd0) begin failures++; $display("FAIL reset_out_data got=%0h/%0d exp=0/0", sif.out_data, sif.out_num_errors); end
        checks++; if (stat_words !== 16'h0 || stat_corr !== 16'h0 || stat_uncorr !== 16'h0) begin failures++; $display("FAIL reset_stats got=%0h/%0h/%0h exp=0/0/0", stat_words, stat_corr, stat_uncorr); end
    endtask

    task automatic test_enc_only();
        int lat; logic done;
        configure(2'b00, 2'b00);
        push_and_wait(32'hFFFF_FFFA, 32'h0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL enc_latency got=%0d exp=3", lat); end
        checks++; if (sif.out_data !== 32'h0000_00AA) begin failures++; $display("FAIL enc_data got=%0h exp=aa", sif.out_data); end
        checks++; if (sif.out_num_errors !== 2'd0) begin failures++; $display("FAIL enc_num got=%0d exp=0", sif.out_num_errors); end
        accept(done);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL enc_done got=%0b exp=1", done); end
        checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL enc_after got=%0b%0b exp=00", sif.out_valid, busy); end
    endtask

    task automatic test_full_channel();
        int lat; logic done;
        configure(2'b10, 2'b10);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++; if (stat_words !== 16'h0) begin failures++; $display("FAIL full_clr got=%0d exp=0", stat_words); end
        push_and_wait(32'hFEAA_AAAA, 32'h0000_0001, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL full_latency got=%0d exp=4", lat); end
        checks++; if (sif.out_data !== 32'h02AA_AAAA || sif.out_num_errors !== 2'd1) begin failures++; $display("FAIL full_corr got=%0h/%0d exp=2aaaaaa/1", sif.out_data, sif.out_num_errors); end
        accept(done);
        push_and_wait(32'h02AA_AAAA, 32'h0000_0003, lat);
        checks++; if (sif.out_data !== 32'h02AA_AAA9 || sif.out_num_errors !== 2'd2) begin failures++; $display("FAIL full_uncorr got=%0h/%0d exp=2aaaaa9/2", sif.out_data, sif.out_num_errors); end
        accept(done);
        checks++; if (stat_words !== 16'd2 || stat_corr !== 16'd1 || stat_uncorr !== 16'd1) begin failures++; $display("FAIL full_stats got=%0d/%0d/%0d exp=2/1/1", stat_words, stat_corr, stat_uncorr); end
    endtask

    task automatic test_dec_only();
        int lat; logic done;
        configure(2'b01, 2'b01);
        push_and_wait(32'hFFFF_9C01, 32'hFFFF_0000, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL dec_latency got=%0d exp=3", lat); end
        checks++; if (sif.out_data !== 32'h1 || sif.out_num_errors !== 2'd1) begin failures++; $display("FAIL dec_info_bit got=%0h/%0d exp=1/1", sif.out_data, sif.out_num_errors); end
        accept(done);
        push_and_wait(32'h0000_1801, 32'h0, lat);
        checks++; if (sif.out_data !== 32'h1 || sif.out_num_errors !== 2'd1) begin failures++; $display("FAIL dec_overall_bit got=%0h/%0d exp=1/1", sif.out_data, sif.out_num_errors); end
        accept(done);
        push_and_wait(32'h0000_9001, 32'h0, lat);
        checks++; if (sif.out_data !== 32'h1 || sif.out_num_errors !== 2'd1) begin failures++; $display("FAIL dec_parity_bit got=%0h/%0d exp=1/1", sif.out_data, sif.out_num_errors); end
        accept(done);
        push_and_wait(32'h0000_9801, 32'h0, lat);
        checks++; if (sif.out_data !== 32'h1 || sif.out_num_errors !== 2'd0) begin failures++; $display("FAIL dec_clean got=%0h/%0d exp=1/0", sif.out_data, sif.out_num_errors); end
        accept(done);
        push_and_wait(32'h0000_9802, 32'h0, lat);
        checks++; if (sif.out_data !== 32'h2 || sif.out_num_errors !== 2'd2) begin failures++; $display("FAIL dec_double got=%0h/%0d exp=2/2", sif.out_data, sif.out_num_errors); end
        accept(done);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_cw [9] = '{8'h00, 8'hB1, 8'hD2, 8'h63, 8'hE4, 8'h55, 8'h36, 8'h87, 8'h78};
        int  accepted = 0;
        int  idx = 0;
        logic acc;
        configure(2'b00, 2'b00);
        sif.out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            sif.in_valid = 1'b1; sif.in_data = 32'(accepted); sif.in_noise = '0;
            acc = sif.in_ready;
            @(negedge clk);
            if (acc) accepted++;
        end
        sif.in_valid = 1'b0;
        checks++; if (accepted !== 9) begin failures++; $display("FAIL b2b_accepted got=%0d exp=9", accepted); end
        checks++; if (sif.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0b exp=0", sif.in_ready); end
        sif.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && idx < 9; c++) begin
            if (sif.out_valid === 1'b1) begin
                checks++; if (sif.out_data !== {24'h0, exp_cw[idx]}) begin failures++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", idx, sif.out_data, exp_cw[idx]); end
                checks++; if (operation_done !== (idx == 8)) begin failures++; $display("FAIL b2b_done[%0d] got=%0b exp=%0b", idx, operation_done, idx == 8); end
                idx++;
            end
            @(negedge clk);
        end
        sif.out_ready = 1'b0;
        checks++; if (idx !== 9 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d/%0b exp=9/0", idx, busy); end
    endtask

    task automatic test_cfg_busy();
        int lat; logic done;
        configure(2'b00, 2'b00);
        push_and_wait(32'h1, 32'h0, lat);
        cfg_we = 1'b1; cfg_mode = 2'b01; cfg_width = 2'b10;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse got=%0b exp=1", cfg_err); end
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got=%0b exp=0", cfg_err); end
        accept(done);
        push_and_wait(32'h1, 32'h0, lat);
        checks++; if (lat !== 3 || sif.out_data !== 32'hB1) begin failures++; $display("FAIL cfg_unchanged got=%0d/%0h exp=3/b1", lat, sif.out_data); end
        accept(done);
        configure(2'b00, 2'b11);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_idle_err got=%0b exp=0", cfg_err); end
        push_and_wait(32'h1, 32'h0, lat);
        checks++; if (sif.out_data !== 32'h8C00_0001) begin failures++; $display("FAIL cfg_new_width got=%0h exp=8c000001", sif.out_data); end
        accept(done);
    endtask

    task automatic test_mid_reset();
        int lat; logic done;
        configure(2'b10, 2'b01);
        push_and_wait(32'h1, 32'h0, lat);
        accept(done);
        push_and_wait(32'h1, 32'h0, lat);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_stream got=%0b%0b exp=01", sif.out_valid, sif.in_ready); end
        checks++; if (stat_words !== 16'h0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0d/%0b exp=0/0", stat_words, busy); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_dropped got=%0b exp=0", sif.out_valid); end
        push_and_wait(32'h1, 32'h0, lat);
        checks++; if (lat !== 3 || sif.out_data !== 32'h8C00_0001) begin failures++; $display("FAIL midrst_cfg got=%0d/%0h exp=3/8c000001", lat, sif.out_data); end
        accept(done);
        checks++; if (stat_words !== 16'd1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", stat_words); end
        push_and_wait(32'h1, 32'h0, lat);
        sif.out_ready = 1'b1; stat_clr = 1'b1;
        @(negedge clk);
        sif.out_ready = 1'b0; stat_clr = 1'b0;
        checks++; if (stat_words !== 16'h0 || sif.out_valid !== 1'b0) begin failures++; $display("FAIL clr_priority got=%0d/%0b exp=0/0", stat_words, sif.out_valid); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_enc_only();
        test_full_channel();
        test_dec_only();
        test_back_to_back();
        test_cfg_busy();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
